multicycle_datapath: RTL and testbench
======================================

# multicycle_datapath

Parametrised multicycle successor to the single-cycle 8-bit datapath. It owns the program counter, a 16-entry register file, the ALU and an internal control FSM, and it executes a 16-bit instruction stream. Instruction and data memory are external, behind req/ack handshakes, so they may have variable latency. It sits between the instruction ROM and data RAM wrappers and the top level.

## Interface
- `DATA_W`, default 8: register, ALU and data-memory word width; must be ≥ 8.
- `PC_W`, default 5: program counter and instruction address width.
- `DMEM_AW`, default 4: data memory address width; must be ≤ 8.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: launches execution from IDLE.
- `imem_req` out 1: instruction fetch request.
- `imem_addr` out PC_W: fetch address, equal to PC.
- `imem_ack` in 1: fetch complete; `imem_rdata` is valid in the same cycle.
- `imem_rdata` in 16: instruction word.
- `dmem_req` out 1: data access request.
- `dmem_we` out 1: 1 for a store, 0 for a load.
- `dmem_addr` out DMEM_AW: data address.
- `dmem_wdata` out DATA_W: store data.
- `dmem_ack` in 1: access complete; `dmem_rdata` is valid in the same cycle for loads.
- `dmem_rdata` in DATA_W: load data.
- `retire` out 1: one-cycle pulse per completed instruction.
- `halted` out 1: high while in HALT.
- `pc` out PC_W: current PC.

## Operation
- Instruction fields: `op`=[15:12], `rd`=[11:8], `ra`=[7:4], `rb`=[3:0], `imm8`=[7:0].
- `0000` ADD: R[rd] ← R[ra] + R[rb], modulo 2^DATA_W.
- `0001` SUB: R[rd] ← R[ra] − R[rb], modulo 2^DATA_W.
- `0010` AND: R[rd] ← R[ra] & R[rb].
- `0011` LDI: R[rd] ← zero-extended `imm8`.
- `0100` LD: R[rd] ← DMEM[imm8[DMEM_AW-1:0]].
- `0101` ST: DMEM[imm8[DMEM_AW-1:0]] ← R[rd].
- `0110` BEQZ: if R[rd]==0, PC ← imm8[PC_W-1:0] (zero-extended if PC_W > 8); else PC+1.
- `0111` HALT: stop execution.
- All other opcodes are NOPs: PC+1, no state change other than PC, and `retire` still pulses.
- PC increment wraps modulo 2^PC_W (for example 31 → 0 at PC_W=5).
- FSM states and transitions:
  - IDLE → FETCH on `start`.
  - FETCH → EXEC on `imem_ack`; the instruction register latches `imem_rdata`.
  - EXEC → FETCH for ALU, LDI, BEQZ and NOP.
  - EXEC → MEM for LD and ST.
  - EXEC → HALT for HALT.
  - MEM → FETCH on `dmem_ack`.
  - HALT is left only by reset.
- `start` outside IDLE is ignored.
- A read of the register being written in the same cycle returns the old value.

## Timing
- Reset values: state IDLE, PC=0, all registers 0, instruction register 0, and every output 0 (`imem_addr`=0, `pc`=0).
- `imem_req` is high for every FETCH cycle. `imem_addr` is stable from request to ack.
- An ack in the first request cycle is legal; zero-wait fetch costs 1 cycle.
- `dmem_req`, `dmem_we`, `dmem_addr` and `dmem_wdata` are held constant throughout MEM until ack.
- An `imem_ack` or `dmem_ack` arriving while the matching req is low is ignored.
- Register writeback and PC update happen on the edge that leaves EXEC, or on the `dmem_ack` edge for LD and ST.
- `retire` pulses in the cycle of that edge. HALT also pulses `retire` once as it enters HALT.
- Latency with zero-wait memories:
  - ALU, LDI, BEQZ, NOP: 2 cycles.
  - LD, ST: 3 cycles.
  - Each memory wait cycle adds 1 cycle.
- `halted` rises in the cycle after the HALT instruction leaves EXEC.
- Reset asserted mid-transaction drops `imem_req`/`dmem_req` immediately, without waiting for ack. The memories must tolerate an abandoned request.

## Configuration
- `MDP_ZERO_REG_EN` defined:
  - R0 reads as 0 at all times and writes to R0 are discarded.
  - BEQZ on R0 is an unconditional jump.
- Undefined: R0 is an ordinary writable register.

## Test plan
- Reset, then `start`, zero-wait memories, program LDI R1,5; LDI R2,3; ADD R3,R1,R2; HALT:
  - R3=8.
  - `retire` pulses 4 times.
  - `halted`=1 after 8 cycles.
- DATA_W=8, R1=0xFF, R2=0x01, ADD R4,R1,R2 → R4=0x00. SUB R5,R2,R1 → R5=0x02.
- ST R1 to address 7, then LD R6 from 7, with `dmem_ack` delayed 3 cycles:
  - R6=R1.
  - Request signals stable through the wait.
  - LD retires 6 cycles after its fetch begins.
- BEQZ R0 to 0x10 with R0=0 → next `imem_addr`=0x10. PC_W=5 with PC=31 and a NOP → next PC=0.
- Write R0=9 then BEQZ R0:
  - `MDP_ZERO_REG_EN` defined → branch taken.
  - Undefined → not taken, PC+1.
- Assert `reset` while `dmem_req`=1 mid-wait:
  - `dmem_req` is 0 in the same cycle.
  - State is IDLE, PC=0 and registers are 0.
  - `start` then runs the program from address 0.

Source files
------------

// File: rtl/multicycle_datapath_if.sv
// -----------------------------------------------------------------------------
// multicycle_datapath_if
//   Instruction and data memory bus for multicycle_datapath.
//
//   Handshake: the requester raises *_req and holds it, and every request
//   qualifier (address, write enable, write data), constant until the
//   responder answers. *_ack is a single-cycle completion strobe. Read data is
//   sampled in the same cycle as ack. An ack seen while the matching req is low
//   carries no meaning and is ignored. A requester may drop req without an ack
//   only through reset, which abandons the access.
//
//   Parameters: PC_W (instruction address width), DATA_W (data word width),
//               DMEM_AW (data address width).
//   Modports  : master - datapath side (drives req/addr/we/wdata)
//               slave  - memory side   (drives ack/rdata)
// -----------------------------------------------------------------------------
interface multicycle_datapath_if #(
  parameter int PC_W    = 5,
  parameter int DATA_W  = 8,
  parameter int DMEM_AW = 4
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [15:0]        imem_rdata;

  logic               dmem_req;
  logic               dmem_we;
  logic [DMEM_AW-1:0] dmem_addr;
  logic [DATA_W-1:0]  dmem_wdata;
  logic               dmem_ack;
  logic [DATA_W-1:0]  dmem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/multicycle_datapath.sv
// -----------------------------------------------------------------------------
// multicycle_datapath
//   Multicycle CPU datapath: program counter, 16-entry register file, ALU and
//   control FSM (IDLE -> FETCH -> EXEC -> [MEM] -> FETCH ..., HALT terminal).
//   Instruction/data memories sit behind req/ack handshakes on the mem bus.
//
//   Optional feature macro: MDP_ZERO_REG_EN
//     defined   : R0 always reads 0, writes to R0 are dropped.
//     undefined : R0 is an ordinary register.
//
//   Ports:
//     clk        - clock, rising edge
//     reset      - asynchronous, active-low reset
//     start      - launch execution from IDLE (ignored elsewhere)
//     mem        - instruction/data memory bus (master side)
//     retire     - one-cycle pulse per completed instruction (HALT included)
//     halted     - high while in HALT
//     pc         - current program counter
//     fsm_state  - current control state (IDLE=0 FETCH=1 EXEC=2 MEM=3 HALT=4)
// -----------------------------------------------------------------------------
module multicycle_datapath #(
  parameter int DATA_W  = 8,
  parameter int PC_W    = 5,
  parameter int DMEM_AW = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  multicycle_datapath_if.master  mem,
  output logic                   retire,
  output logic                   halted,
  output logic [PC_W-1:0]        pc,
  output logic [2:0]             fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_LDI  = 4'h3;
  localparam logic [3:0] OP_LD   = 4'h4;
  localparam logic [3:0] OP_ST   = 4'h5;
  localparam logic [3:0] OP_BEQZ = 4'h6;
  localparam logic [3:0] OP_HALT = 4'h7;

  state_t            state_q, state_d;
  logic [15:0]       ir_q;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] rf_q [16];

  logic              ir_load;
  logic              wr_en;
  logic              wr_ok;
  logic [DATA_W-1:0] wr_data;

  logic [3:0]        op, rd, ra, rb;
  logic [7:0]        imm8;
  logic [DATA_W-1:0] rd_val, ra_val, rb_val;
  logic [DATA_W-1:0] alu_res;
  logic [PC_W-1:0]   pc_inc, br_target;

  assign op   = ir_q[15:12];
  assign rd   = ir_q[11:8];
  assign ra   = ir_q[7:4];
  assign rb   = ir_q[3:0];
  assign imm8 = ir_q[7:0];

  // Register read. Reads see the registered value, so a read of the register
  // being written on the same edge returns the old contents.
  function automatic logic [DATA_W-1:0] read_reg(input logic [3:0] idx);
`ifdef MDP_ZERO_REG_EN
    if (idx == 4'd0) return '0;
`endif
    return rf_q[idx];
  endfunction

  assign rd_val = read_reg(rd);
  assign ra_val = read_reg(ra);
  assign rb_val = read_reg(rb);

`ifdef MDP_ZERO_REG_EN
  assign wr_ok = wr_en && (rd != 4'd0);
`else
  assign wr_ok = wr_en;
`endif

  // PC arithmetic wraps naturally at PC_W bits. The branch target cast
  // truncates imm8 when PC_W < 8 and zero-extends it when PC_W > 8.
  assign pc_inc    = pc_q + PC_W'(1);
  assign br_target = PC_W'(imm8);

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = ra_val + rb_val;
      OP_SUB:  alu_res = ra_val - rb_val;
      OP_AND:  alu_res = ra_val & rb_val;
      default: alu_res = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state, architectural update controls and retire strobe
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_load = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    retire  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem.imem_ack) begin
          ir_load = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND: begin
            wr_en   = 1'b1;
            wr_data = alu_res;
            pc_d    = pc_inc;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          OP_LDI: begin
            wr_en   = 1'b1;
            wr_data = DATA_W'(imm8);
            pc_d    = pc_inc;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          OP_LD, OP_ST: begin
            state_d = S_MEM;
          end
          OP_BEQZ: begin
            pc_d    = (rd_val == '0) ? br_target : pc_inc;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          OP_HALT: begin
            // PC is left pointing at the HALT instruction.
            retire  = 1'b1;
            state_d = S_HALT;
          end
          default: begin
            pc_d    = pc_inc;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        if (mem.dmem_ack) begin
          if (op == OP_LD) begin
            wr_en   = 1'b1;
            wr_data = mem.dmem_rdata;
          end
          pc_d    = pc_inc;
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Architectural state: PC, instruction register, register file
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= '0;
      ir_q <= '0;
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      if (ir_load) ir_q <= mem.imem_rdata;
      if (wr_ok)   rf_q[rd] <= wr_data;
    end
  end

  // Bus outputs decode straight from the state register, so an asynchronous
  // reset drops both requests immediately. The MEM qualifiers come from ir_q
  // and an rd register that is not written during MEM, so they hold until ack.
  assign mem.imem_req   = (state_q == S_FETCH);
  assign mem.imem_addr  = pc_q;
  assign mem.dmem_req   = (state_q == S_MEM);
  assign mem.dmem_we    = (state_q == S_MEM) && (op == OP_ST);
  assign mem.dmem_addr  = (state_q == S_MEM) ? imm8[DMEM_AW-1:0] : '0;
  assign mem.dmem_wdata = (state_q == S_MEM) ? rd_val : '0;

  assign halted    = (state_q == S_HALT);
  assign pc        = pc_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_multicycle_datapath.sv
// -----------------------------------------------------------------------------
// tb_multicycle_datapath
//   Bench for multicycle_datapath with behavioural instruction/data memories
//   of programmable latency. Register values are observed through ST
//   instructions; every expected store value is queued before the run and
//   compared when the store completes on the bus.
// -----------------------------------------------------------------------------
module tb_multicycle_datapath;
  localparam int DATA_W  = 8;
  localparam int PC_W    = 5;
  localparam int DMEM_AW = 4;

  localparam logic [3:0] OPC_ADD  = 4'h0;
  localparam logic [3:0] OPC_SUB  = 4'h1;
  localparam logic [3:0] OPC_AND  = 4'h2;
  localparam logic [3:0] OPC_LDI  = 4'h3;
  localparam logic [3:0] OPC_LD   = 4'h4;
  localparam logic [3:0] OPC_ST   = 4'h5;
  localparam logic [3:0] OPC_BEQZ = 4'h6;
  localparam logic [15:0] I_HALT  = 16'h7000;
  localparam logic [15:0] I_NOP   = 16'h8000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic start;
  logic retire, halted;
  logic [PC_W-1:0] pc;
  logic [2:0] fsm_state;

  always #5 clk = ~clk;

  multicycle_datapath_if #(.PC_W(PC_W), .DATA_W(DATA_W), .DMEM_AW(DMEM_AW)) mem_bus ();

  multicycle_datapath #(.DATA_W(DATA_W), .PC_W(PC_W), .DMEM_AW(DMEM_AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mem       (mem_bus),
    .retire    (retire),
    .halted    (halted),
    .pc        (pc),
    .fsm_state (fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] exp_q[$];

  logic [15:0]       imem [32];
  logic [DATA_W-1:0] dmem [16];
  int  iwait = 0;
  int  dwait = 0;
  bit  spur  = 1'b0;

  int  cyc = 0;
  int  fetch_start = 0;
  int  retire_cnt = 0;
  int  lat_log[$];
  int  fetch_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_fetch(input int idx, input int exp, input string name);
    if (idx < fetch_log.size()) check(name, 32'(fetch_log[idx]), 32'(exp));
    else check({name, "_len"}, 32'(fetch_log.size()), 32'(idx + 1));
  endtask

  task automatic check_lat(input int idx, input int exp, input string name);
    if (idx < lat_log.size()) check(name, 32'(lat_log[idx]), 32'(exp));
    else check({name, "_len"}, 32'(lat_log.size()), 32'(idx + 1));
  endtask

  // ---------------- memory responders + bus monitor ----------------
  initial begin : responder
    int icnt;
    int dcnt;
    logic pi_req, pi_ack, pd_req, pd_ack, pd_we;
    logic [PC_W-1:0] pi_addr;
    logic [DMEM_AW-1:0] pd_addr;
    logic [DATA_W-1:0] pd_wdata;
    icnt = 0; dcnt = 0;
    pi_req = 0; pi_ack = 0; pd_req = 0; pd_ack = 0; pd_we = 0;
    pi_addr = '0; pd_addr = '0; pd_wdata = '0;
    mem_bus.imem_ack   = 1'b0;
    mem_bus.imem_rdata = '0;
    mem_bus.dmem_ack   = 1'b0;
    mem_bus.dmem_rdata = '0;
    forever begin
      @(negedge clk);
      // drive acks for the coming rising edge
      if (mem_bus.imem_req) begin
        if (icnt >= iwait) begin
          mem_bus.imem_ack   = 1'b1;
          mem_bus.imem_rdata = imem[mem_bus.imem_addr];
        end else begin
          mem_bus.imem_ack = 1'b0;
          icnt++;
        end
      end else begin
        mem_bus.imem_ack = 1'b0;
        icnt = 0;
      end
      if (mem_bus.dmem_req) begin
        if (dcnt >= dwait) begin
          mem_bus.dmem_ack = 1'b1;
          if (mem_bus.dmem_we) dmem[mem_bus.dmem_addr] = mem_bus.dmem_wdata;
          else mem_bus.dmem_rdata = dmem[mem_bus.dmem_addr];
        end else begin
          mem_bus.dmem_ack = 1'b0;
          dcnt++;
        end
      end else begin
        mem_bus.dmem_ack = spur;
        dcnt = 0;
      end
      #1;
      cyc++;
      if (reset) begin
        if (mem_bus.imem_req && !pi_req) fetch_start = cyc;
        if (mem_bus.imem_req && mem_bus.imem_ack) fetch_log.push_back(int'(mem_bus.imem_addr));
        if (mem_bus.imem_req && pi_req && !pi_ack)
          check("imem_addr_stable", 32'(mem_bus.imem_addr), 32'(pi_addr));
        if (mem_bus.dmem_req && pd_req && !pd_ack) begin
          check("dmem_we_stable",    32'(mem_bus.dmem_we),    32'(pd_we));
          check("dmem_addr_stable",  32'(mem_bus.dmem_addr),  32'(pd_addr));
          check("dmem_wdata_stable", 32'(mem_bus.dmem_wdata), 32'(pd_wdata));
        end
        if (mem_bus.dmem_req && mem_bus.dmem_ack && mem_bus.dmem_we) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL store_unexpected: got 0x%0h at addr %0d, expected no store",
                     mem_bus.dmem_wdata, mem_bus.dmem_addr);
          end else begin
            check("store_data", 32'(mem_bus.dmem_wdata), 32'(exp_q.pop_front()));
          end
        end
        if (retire) begin
          retire_cnt++;
          lat_log.push_back(cyc - fetch_start + 1);
        end
        pi_req = mem_bus.imem_req;  pi_ack = mem_bus.imem_ack;  pi_addr = mem_bus.imem_addr;
        pd_req = mem_bus.dmem_req;  pd_ack = mem_bus.dmem_ack;  pd_we = mem_bus.dmem_we;
        pd_addr = mem_bus.dmem_addr; pd_wdata = mem_bus.dmem_wdata;
      end else begin
        pi_req = 1'b0;
        pd_req = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [15:0] rr(input logic [3:0] op, input logic [3:0] rd,
                                     input logic [3:0] ra, input logic [3:0] rb);
    return {op, rd, ra, rb};
  endfunction

  function automatic logic [15:0] ri(input logic [3:0] op, input logic [3:0] rd,
                                     input logic [7:0] imm);
    return {op, rd, imm};
  endfunction

  task automatic load_clear();
    for (int i = 0; i < 32; i++) imem[i] = I_HALT;
    for (int i = 0; i < 16; i++) dmem[i] = '0;
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_req"},   32'(mem_bus.imem_req),   32'd0);
    check({tag, "_imem_addr"},  32'(mem_bus.imem_addr),  32'd0);
    check({tag, "_dmem_req"},   32'(mem_bus.dmem_req),   32'd0);
    check({tag, "_dmem_we"},    32'(mem_bus.dmem_we),    32'd0);
    check({tag, "_dmem_addr"},  32'(mem_bus.dmem_addr),  32'd0);
    check({tag, "_dmem_wdata"}, 32'(mem_bus.dmem_wdata), 32'd0);
    check({tag, "_retire"},     32'(retire),             32'd0);
    check({tag, "_halted"},     32'(halted),             32'd0);
    check({tag, "_pc"},         32'(pc),                 32'd0);
    check({tag, "_state"},      32'(fsm_state),          32'd0);
  endtask

  task automatic do_reset();
    start = 1'b0;
    reset = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Starts the loaded program and waits (bounded) for HALT. cycles counts
  // rising edges after the one that samples start.
  task automatic run(input bit with_reset, input bit hold_start, output int cycles);
    if (with_reset) do_reset();
    retire_cnt = 0;
    fetch_log.delete();
    lat_log.delete();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #2;
    if (!hold_start) start = 1'b0;
    cycles = 0;
    while (!halted && cycles < 400) begin
      @(posedge clk);
      #2;
      cycles++;
    end
    start = 1'b0;
    check("run_halted", 32'(halted), 32'd1);
    check("stores_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- test ----------------
  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    int         iw;
    int         dw;
    bit         spur_ack;
    bit         hold;
  } vec_t;

  initial begin : global_timeout
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t vecs[6];
    int cycles;
    int guard;

    reset = 1'b0;
    start = 1'b0;

    vecs[0] = '{OPC_ADD, 8'h05, 8'h03, 8'h08, 0, 0, 1'b0, 1'b0};
    vecs[1] = '{OPC_ADD, 8'hFF, 8'h01, 8'h00, 0, 0, 1'b0, 1'b0};
    vecs[2] = '{OPC_SUB, 8'h01, 8'hFF, 8'h02, 1, 2, 1'b0, 1'b0};
    vecs[3] = '{OPC_AND, 8'hF0, 8'h3C, 8'h30, 2, 0, 1'b0, 1'b1};
    vecs[4] = '{OPC_SUB, 8'h03, 8'h05, 8'hFE, 0, 1, 1'b1, 1'b0};
    vecs[5] = '{OPC_ADD, 8'h80, 8'h80, 8'h00, 1, 0, 1'b1, 1'b1};

    // Basic program: LDI R1,5; LDI R2,3; ADD R3,R1,R2; HALT
    load_clear();
    iwait = 0; dwait = 0;
    imem[0] = ri(OPC_LDI, 4'd1, 8'd5);
    imem[1] = ri(OPC_LDI, 4'd2, 8'd3);
    imem[2] = rr(OPC_ADD, 4'd3, 4'd1, 4'd2);
    imem[3] = I_HALT;
    run(1'b1, 1'b0, cycles);
    check("basic_cycles", 32'(cycles), 32'd8);
    check("basic_retires", 32'(retire_cnt), 32'd4);
    for (int i = 0; i < 4; i++) check_lat(i, 2, "basic_latency");

    // ALU table: LDI R1,a; LDI R2,b; OP R3,R1,R2; ST R3,0; HALT
    foreach (vecs[k]) begin
      load_clear();
      iwait = vecs[k].iw;
      dwait = vecs[k].dw;
      spur  = vecs[k].spur_ack;
      imem[0] = ri(OPC_LDI, 4'd1, vecs[k].a);
      imem[1] = ri(OPC_LDI, 4'd2, vecs[k].b);
      imem[2] = rr(vecs[k].op, 4'd3, 4'd1, 4'd2);
      imem[3] = ri(OPC_ST, 4'd3, 8'd0);
      imem[4] = I_HALT;
      exp_q.push_back(vecs[k].res);
      run(1'b1, vecs[k].hold, cycles);
      check("vec_cycles", 32'(cycles), 32'(11 + vecs[k].dw + 5 * vecs[k].iw));
      check("vec_retires", 32'(retire_cnt), 32'd5);
      check_lat(2, 2 + vecs[k].iw, "vec_alu_latency");
      check_lat(3, 3 + vecs[k].iw + vecs[k].dw, "vec_st_latency");
    end
    spur = 1'b0;
    iwait = 0;

    // Store then load with 3 data wait cycles
    load_clear();
    dwait = 3;
    imem[0] = ri(OPC_LDI, 4'd1, 8'h5A);
    imem[1] = ri(OPC_ST,  4'd1, 8'd7);
    imem[2] = ri(OPC_LD,  4'd6, 8'd7);
    imem[3] = ri(OPC_ST,  4'd6, 8'd8);
    imem[4] = I_HALT;
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h5A);
    run(1'b1, 1'b0, cycles);
    check("ldst_cycles", 32'(cycles), 32'd22);
    check_lat(1, 6, "st_latency");
    check_lat(2, 6, "ld_latency");
    check("ldst_mem8", 32'(dmem[8]), 32'h5A);
    dwait = 0;

    // BEQZ R0 to 0x10
    load_clear();
    imem[0]  = ri(OPC_BEQZ, 4'd0, 8'h10);
    imem[1]  = ri(OPC_LDI,  4'd1, 8'h44);
    imem[2]  = ri(OPC_ST,   4'd1, 8'd0);
    imem[16] = ri(OPC_LDI,  4'd1, 8'h33);
    imem[17] = ri(OPC_ST,   4'd1, 8'd0);
    imem[18] = I_HALT;
    exp_q.push_back(8'h33);
    run(1'b1, 1'b0, cycles);
    check_fetch(1, 16, "beqz_target");

    // PC wrap 31 -> 0 through a NOP
    load_clear();
    imem[0]  = ri(OPC_BEQZ, 4'd1, 8'd30);
    imem[30] = ri(OPC_LDI,  4'd1, 8'd1);
    imem[31] = I_NOP;
    imem[1]  = ri(OPC_ST,   4'd1, 8'd0);
    imem[2]  = I_HALT;
    exp_q.push_back(8'h01);
    run(1'b1, 1'b0, cycles);
    check_fetch(1, 30, "wrap_seq1");
    check_fetch(2, 31, "wrap_seq2");
    check_fetch(3, 0,  "wrap_pc_wrap");
    check_fetch(4, 1,  "wrap_seq4");
    check("wrap_retires", 32'(retire_cnt), 32'd6);

    // Write R0 then BEQZ R0
    load_clear();
    imem[0] = ri(OPC_LDI,  4'd0, 8'd9);
    imem[1] = ri(OPC_ST,   4'd0, 8'd1);
    imem[2] = ri(OPC_BEQZ, 4'd0, 8'd6);
    imem[3] = ri(OPC_LDI,  4'd2, 8'h11);
    imem[4] = ri(OPC_ST,   4'd2, 8'd0);
    imem[5] = I_HALT;
    imem[6] = ri(OPC_LDI,  4'd2, 8'h22);
    imem[7] = ri(OPC_ST,   4'd2, 8'd0);
    imem[8] = I_HALT;
`ifdef MDP_ZERO_REG_EN
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h22);
    run(1'b1, 1'b0, cycles);
    check_fetch(3, 6, "r0_branch");
`else
    exp_q.push_back(8'h09);
    exp_q.push_back(8'h11);
    run(1'b1, 1'b0, cycles);
    check_fetch(3, 3, "r0_branch");
`endif

    // Reset in the middle of a data wait
    load_clear();
    dwait = 5;
    imem[0] = ri(OPC_ST,  4'd1, 8'd3);
    imem[1] = ri(OPC_LDI, 4'd1, 8'h2A);
    imem[2] = ri(OPC_ST,  4'd1, 8'd7);
    imem[3] = I_HALT;
    exp_q.push_back(8'h00);
    do_reset();
    retire_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    guard = 0;
    while (!(mem_bus.dmem_req && pc == 5'd2) && guard < 100) begin
      @(negedge clk);
      #2;
      guard++;
    end
    check("midwait_reached", 32'(guard < 100), 32'd1);
    @(negedge clk);
    check("midwait_req_before", 32'(mem_bus.dmem_req), 32'd1);
    #3;
    reset = 1'b0;
    #1;
    check("midwait_first_store", 32'(exp_q.size()), 32'd0);
    check_reset_outputs("midwait");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    dwait = 0;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h2A);
    run(1'b0, 1'b0, cycles);
    check_fetch(0, 0, "restart_addr");
    check("restart_cycles", 32'(cycles), 32'd10);
    check("restart_mem7", 32'(dmem[7]), 32'h2A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
